// File: rtl/axis_peak_arb.sv
// Round-robin arbiter merging NUM_PORTS AXI-stream burst sources onto one output.
// A grant is held for a whole burst; a beat-count watchdog forces tlast on runaway bursts.
module axis_peak_arb #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned BURST_LENGTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [$clog2(NUM_PORTS)-1:0]     m_axis_tuser,
  output logic                             busy,
  output logic                             trunc_err
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);
  localparam int unsigned CNT_W = $clog2(BURST_LENGTH);
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LENGTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tvalid_d, tlast_d, trunc_d;
  logic [DATA_WIDTH-1:0] tdata_d;
  logic [IDX_W-1:0]      tuser_d;

  logic                  sel_tvalid, sel_tlast, out_free, accept, at_limit;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic                  req_found;
  logic [IDX_W-1:0]      req_pick;
  int unsigned           cand;

  assign sel_tvalid = s_axis_tvalid[grant_q];
  assign sel_tlast  = s_axis_tlast[grant_q];
  assign sel_tdata  = s_axis_tdata[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
  assign out_free   = !m_axis_tvalid || m_axis_tready;
  assign accept     = (state_q == BURST) && out_free && sel_tvalid;
  assign at_limit   = (cnt_q == CNT_LAST);
  assign busy       = (state_q == BURST);

  // First requester after the last winner, wrapping around
  always_comb begin
    req_found = 1'b0;
    req_pick  = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = (32'(rr_q) + i) % NUM_PORTS;
      if (!req_found && s_axis_tvalid[IDX_W'(cand)]) begin
        req_found = 1'b1;
        req_pick  = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == BURST && out_free) s_axis_tready[grant_q] = 1'b1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    tvalid_d = m_axis_tvalid && !m_axis_tready;
    tdata_d  = m_axis_tdata;
    tlast_d  = m_axis_tlast;
    tuser_d  = m_axis_tuser;
    trunc_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && req_found) begin
          grant_d = req_pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          tvalid_d = 1'b1;
          tdata_d  = sel_tdata;
          tuser_d  = grant_q;
          tlast_d  = sel_tlast || at_limit;
          trunc_d  = at_limit && !sel_tlast;
          cnt_d    = cnt_q + CNT_W'(1);
          if (sel_tlast || at_limit) begin
            state_d = IDLE;
            rr_d    = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_q          <= RR_RESET;
      cnt_q         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      trunc_err     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tlast  <= tlast_d;
      m_axis_tuser  <= tuser_d;
      trunc_err     <= trunc_d;
    end
  end

endmodule

// File: tb/tb_axis_peak_arb.sv
// Bench for axis_peak_arb: randomized sources and sink, cycle model of the arbitration
// rules, per-port data scoreboard, and literal burst-order/latency checks.
module tb_axis_peak_arb;
  localparam int NP = 4;
  localparam int DW = 256;
  localparam int BL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic [NP-1:0] s_tvalid = '0, s_tready, s_tlast = '0;
  logic [NP*DW-1:0] s_tdata = '0;
  logic m_tvalid, m_tready = 1'b1, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [1:0] m_tuser;
  logic busy, trunc_err;

  axis_peak_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .BURST_LENGTH(BL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .busy(busy), .trunc_err(trunc_err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // sources, scoreboard and statistics
  logic [DW-1:0] src_d [NP][$];
  bit            src_l [NP][$];
  logic [DW-1:0] sb_d  [NP][$];
  bit held [NP];
  bit hs [NP];
  int src_rate = 100, rdy_rate = 100;
  bit en_rand = 0;
  int out_cnt, trunc_cnt, busy_cnt, first_out, cur_len;
  bit in_burst;
  int burst_u[$], burst_n[$];

  // behavioural model: owner (-1 idle), beats taken, last winner, output register
  int e_own = -1, e_rr = NP - 1, e_cnt = 0, e_u = 0;
  bit e_v = 0, e_l = 0, e_t = 0;
  logic [DW-1:0] e_d = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge clk) begin
    bit fr, found;
    int p;
    cyc++;
    if (!rst_n) begin
      e_own = -1; e_rr = NP - 1; e_cnt = 0; e_u = 0;
      e_v = 0; e_l = 0; e_t = 0; e_d = '0;
    end else begin
      fr  = !e_v || m_tready;
      e_t = 0;
      if (e_v && m_tready) e_v = 0;
      if (e_own < 0) begin
        found = 0;
        if (enable) begin
          for (int k = 1; k <= NP; k++) begin
            p = (e_rr + k) % NP;
            if (!found && s_tvalid[p]) begin
              found = 1; e_own = p; e_cnt = 0;
            end
          end
        end
      end else if (fr && s_tvalid[e_own]) begin
        e_cnt++;
        e_v = 1;
        e_d = s_tdata[e_own*DW +: DW];
        e_u = e_own;
        e_l = s_tlast[e_own] || (e_cnt == BL);
        e_t = (e_cnt == BL) && !s_tlast[e_own];
        if (e_l) begin
          e_rr  = e_own;
          e_own = -1;
        end
      end
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    logic [NP-1:0] exp_rdy;
    int u;
    if (!rst_n) begin
      chk("rst_tvalid", DW'(m_tvalid), '0);
      chk("rst_tdata", m_tdata, '0);
      chk("rst_tlast", DW'(m_tlast), '0);
      chk("rst_tuser", DW'(m_tuser), '0);
      chk("rst_busy", DW'(busy), '0);
      chk("rst_trunc", DW'(trunc_err), '0);
      chk("rst_s_tready", DW'(s_tready), '0);
      for (int p = 0; p < NP; p++) hs[p] = 0;
      in_burst = 0;
    end else begin
      exp_rdy = '0;
      if (e_own >= 0 && (!e_v || m_tready)) exp_rdy[e_own] = 1'b1;
      chk("s_tready", DW'(s_tready), DW'(exp_rdy));
      chk("busy", DW'(busy), DW'(e_own >= 0));
      chk("m_tvalid", DW'(m_tvalid), DW'(e_v));
      chk("trunc_err", DW'(trunc_err), DW'(e_t));
      if (e_v) begin
        chk("m_tdata", m_tdata, e_d);
        chk("m_tlast", DW'(m_tlast), DW'(e_l));
        chki("m_tuser", int'(m_tuser), e_u);
      end
      for (int p = 0; p < NP; p++) hs[p] = s_tvalid[p] && s_tready[p];
      if (busy) busy_cnt++;
      if (trunc_err) trunc_cnt++;
      if (m_tvalid && first_out < 0) first_out = cyc;
      if (m_tvalid && m_tready) begin
        u = int'(m_tuser);
        if (sb_d[u].size() == 0) chki("sb_empty_port", u, -1);
        else chk("sb_data", m_tdata, sb_d[u].pop_front());
        if (!in_burst) begin
          burst_u.push_back(u);
          in_burst = 1;
          cur_len = 0;
        end
        cur_len++;
        out_cnt++;
        if (m_tlast) begin
          burst_n.push_back(cur_len);
          in_burst = 0;
        end
      end
    end
  end

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      if (hs[p] && src_d[p].size() > 0) begin
        void'(src_d[p].pop_front());
        void'(src_l[p].pop_front());
        held[p] = 0;
      end
      if (!held[p] && src_d[p].size() > 0 && $urandom_range(99) < src_rate) held[p] = 1;
      s_tvalid[p] = held[p];
      s_tdata[p*DW +: DW] = held[p] ? src_d[p][0] : '0;
      s_tlast[p] = held[p] ? src_l[p][0] : 1'b0;
    end
    m_tready = ($urandom_range(99) < rdy_rate);
    if (en_rand) enable = ($urandom_range(9) != 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic load_burst(input int p, input int n, input bit with_last);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = rand_beat();
      src_d[p].push_back(d);
      src_l[p].push_back(with_last && (i == n - 1));
      sb_d[p].push_back(d);
    end
  endtask

  task automatic clear_stats();
    out_cnt = 0; trunc_cnt = 0; busy_cnt = 0; first_out = -1;
    burst_u.delete(); burst_n.delete();
  endtask

  task automatic flush();
    for (int p = 0; p < NP; p++) begin
      src_d[p].delete(); src_l[p].delete(); sb_d[p].delete();
      held[p] = 0;
    end
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
  endtask

  function automatic bit pending();
    for (int p = 0; p < NP; p++)
      if (src_d[p].size() > 0 || sb_d[p].size() > 0) return 1;
    return 0;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((pending() || m_tvalid || busy) && n < budget) begin
      step();
      n++;
    end
    chki({name, "_drain_in_budget"}, int'(n < budget), 1);
    repeat (2) step();
  endtask

  task automatic chk_bursts(input string name, input int us[$], input int ns[$]);
    chki({name, "_burst_count"}, burst_u.size(), us.size());
    for (int i = 0; i < us.size() && i < burst_u.size(); i++) begin
      chki({name, "_burst_port"}, burst_u[i], us[i]);
      if (i < burst_n.size()) chki({name, "_burst_len"}, burst_n[i], ns[i]);
    end
  endtask

  initial begin
    int t0, total, n;
    repeat (3) @(posedge clk);

    // single 4-beat burst from port 2, fixed latency
    do_reset();
    load_burst(2, 4, 1);
    step();
    t0 = cyc;
    drain("t1", 100);
    chki("t1_first_beat_latency", first_out - t0, 2);
    chki("t1_beats", out_cnt, 4);
    chk_bursts("t1", '{2}, '{4});
    chki("t1_trunc", trunc_cnt, 0);

    // all ports continuously valid with 3-beat bursts
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) load_burst(p, 3, 1);
    drain("t2", 400);
    chk_bursts("t2", '{0, 1, 2, 3, 0, 1, 2, 3}, '{3, 3, 3, 3, 3, 3, 3, 3});

    // 40-beat runaway burst on port 1 is cut at 32
    do_reset();
    load_burst(1, 40, 1);
    load_burst(2, 2, 1);
    load_burst(3, 2, 1);
    drain("t3", 400);
    chk_bursts("t3", '{1, 2, 3, 1}, '{32, 2, 2, 8});
    chki("t3_trunc", trunc_cnt, 1);

    // tlast exactly on the limit beat is not a truncation
    do_reset();
    load_burst(0, 32, 1);
    drain("t4", 200);
    chk_bursts("t4", '{0}, '{32});
    chki("t4_trunc", trunc_cnt, 0);

    // random traffic with downstream and source stalls
    rdy_rate = 50; src_rate = 70; en_rand = 1;
    do_reset();
    total = 0;
    for (int p = 0; p < NP; p++)
      for (int b = 0; b < 3; b++) begin
        n = $urandom_range(40, 1);
        load_burst(p, n, (b == 2) || ($urandom_range(3) != 0));
        total += n;
      end
    drain("t5", 8000);
    chki("t5_beats", out_cnt, total);
    rdy_rate = 100; src_rate = 100; en_rand = 0; enable = 1'b1;

    // reset mid-burst, then port 0 beats port 3
    do_reset();
    load_burst(0, 10, 1);
    n = 0;
    while (out_cnt < 5 && n < 50) begin
      step();
      n++;
    end
    chki("t6_reached_beat5", out_cnt, 5);
    rst_n = 1'b0;
    flush();
    @(negedge clk);
    chki("t6_rst_tvalid", int'(m_tvalid), 0);
    chki("t6_rst_busy", int'(busy), 0);
    chki("t6_rst_tready", int'(s_tready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
    load_burst(0, 2, 1);
    load_burst(3, 2, 1);
    drain("t6", 100);
    chk_bursts("t6", '{0, 3}, '{2, 2});

    // enable low blocks new grants
    do_reset();
    enable = 1'b0;
    load_burst(1, 3, 1);
    repeat (10) step();
    chki("t7_busy_while_disabled", busy_cnt, 0);
    chki("t7_out_while_disabled", out_cnt, 0);
    enable = 1'b1;
    drain("t7", 100);
    chk_bursts("t7", '{1}, '{3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
